reaction_control: RTL and testbench

REACTION_CONTROL -- requirements
Module: reaction_control

---
 rtl/reaction_pkg.sv | 20 ++
 rtl/button_sync_edge.sv | 36 +++
 rtl/reaction_control.sv | 124 ++++++++++++
 tb/tb_reaction_control.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/reaction_pkg.sv
// rtl/reaction_pkg.sv - shared state encodings and defaults for the reaction timer controller
package reaction_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ARM    = 3'd1,
      ST_WAIT   = 3'd2,
      ST_GO     = 3'd3,
      ST_REACT  = 3'd4,
      ST_LOAD   = 3'd5,
      ST_RESULT = 3'd6,
      ST_ABORT  = 3'd7
   } state_t;

   localparam int HOLD_CYCLES_DEF = 64;
   localparam int UP_MAX_DEF      = 4095;
   localparam int HOLD_CNT_W      = 8;
   localparam int UP_CNT_W        = 12;

endpackage

// File: rtl/button_sync_edge.sv
// rtl/button_sync_edge.sv - two-flop synchronizer plus registered rising-edge detector
// A button already high when reset releases must be seen low before any edge is reported.
module button_sync_edge (
   input  logic clk,
   input  logic iResetn,
   input  logic button,
   output logic pulse
);

   logic       meta;
   logic       sync;
   logic       sync_d;
   logic       seen_low;
   logic [1:0] fill;

   always_ff @(posedge clk or negedge iResetn) begin
      if (!iResetn) begin
         meta     <= 1'b0;
         sync     <= 1'b0;
         sync_d   <= 1'b0;
         seen_low <= 1'b0;
         fill     <= 2'b00;
         pulse    <= 1'b0;
      end else begin
         meta   <= button;
         sync   <= meta;
         sync_d <= sync;
         fill   <= {fill[0], 1'b1};
         // sync only reflects the real pin once the pipeline has refilled after reset
         if (fill[1] && !sync)
            seen_low <= 1'b1;
         pulse  <= sync && !sync_d && seen_low;
      end
   end

endmodule

// File: rtl/reaction_control.sv
// rtl/reaction_control.sv - reaction timer control FSM with registered datapath strobes
module reaction_control
   import reaction_pkg::*;
#(
   parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
   parameter int UP_MAX      = UP_MAX_DEF
) (
   input  logic                clk,
   input  logic                iResetn,
   input  logic                iStart,
   input  logic                iReact,
   input  logic                iCountComplete,
   input  logic [UP_CNT_W-1:0] iUpCount,
   output logic                oStart_down_count,
   output logic                oStart_up_count,
   output logic                oLoad_score,
   output logic                oScreen,
   output logic                oFalseStart,
   output logic                oTimeout,
   output logic [2:0]          oState
);

   localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(HOLD_CYCLES - 1);
   localparam logic [UP_CNT_W-1:0]   UP_LIMIT  = UP_CNT_W'(UP_MAX);

   state_t                state;
   logic [HOLD_CNT_W-1:0] hold_cnt;
   logic                  go_react;
   logic                  start_edge;
   logic                  react_edge;

   button_sync_edge u_start_sync (
      .clk     (clk),
      .iResetn (iResetn),
      .button  (iStart),
      .pulse   (start_edge)
   );

   button_sync_edge u_react_sync (
      .clk     (clk),
      .iResetn (iResetn),
      .button  (iReact),
      .pulse   (react_edge)
   );

   assign oState = state;

   always_ff @(posedge clk or negedge iResetn) begin
      if (!iResetn) begin
         state             <= ST_IDLE;
         hold_cnt          <= '0;
         go_react          <= 1'b0;
         oStart_down_count <= 1'b0;
         oStart_up_count   <= 1'b0;
         oLoad_score       <= 1'b0;
         oScreen           <= 1'b0;
         oFalseStart       <= 1'b0;
         oTimeout          <= 1'b0;
      end else begin
         oLoad_score <= 1'b0;
         case (state)
            ST_IDLE, ST_RESULT, ST_ABORT: begin
               if (start_edge) begin
                  state             <= ST_ARM;
                  hold_cnt          <= '0;
                  oStart_down_count <= 1'b1;
                  oFalseStart       <= 1'b0;
                  oTimeout          <= 1'b0;
               end
            end
            ST_ARM: begin
               if (hold_cnt == HOLD_LAST) begin
                  state             <= ST_WAIT;
                  oStart_down_count <= 1'b0;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            ST_WAIT: begin
               // an early press beats a countdown that completes in the same cycle
               if (react_edge) begin
                  state       <= ST_ABORT;
                  oFalseStart <= 1'b1;
               end else if (iCountComplete) begin
                  state           <= ST_GO;
                  hold_cnt        <= '0;
                  go_react        <= 1'b0;
                  oScreen         <= 1'b1;
                  oStart_up_count <= 1'b1;
               end
            end
            ST_GO: begin
               if (react_edge)
                  go_react <= 1'b1;
               if (hold_cnt == HOLD_LAST) begin
                  state           <= ST_REACT;
                  oStart_up_count <= 1'b0;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            ST_REACT: begin
               if (react_edge || go_react) begin
                  state       <= ST_LOAD;
                  go_react    <= 1'b0;
                  oScreen     <= 1'b0;
                  oLoad_score <= 1'b1;
               end else if (iUpCount == UP_LIMIT) begin
                  state    <= ST_ABORT;
                  oScreen  <= 1'b0;
                  oTimeout <= 1'b1;
               end
            end
            ST_LOAD: begin
               state <= ST_RESULT;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reaction_control.sv
// tb/tb_reaction_control.sv - self-checking bench for reaction_control
module tb_reaction_control;
   import reaction_pkg::*;

   localparam int HOLD = HOLD_CYCLES_DEF;
   localparam int M_FALSE   = 0;
   localparam int M_SIMUL   = 1;
   localparam int M_NORMAL  = 2;
   localparam int M_INGO    = 3;
   localparam int M_TIMEOUT = 4;

   logic        clk = 1'b0;
   logic        iResetn;
   logic        iStart;
   logic        iReact;
   logic        iCountComplete;
   logic [11:0] iUpCount;
   logic        oStart_down_count;
   logic        oStart_up_count;
   logic        oLoad_score;
   logic        oScreen;
   logic        oFalseStart;
   logic        oTimeout;
   logic [2:0]  oState;

   int n_assert = 0;
   int n_fail   = 0;
   int n_down   = 0;
   int n_up     = 0;
   int n_screen = 0;
   int n_load   = 0;
   int n_bad    = 0;

   always #5 clk = ~clk;

   reaction_control dut (
      .clk               (clk),
      .iResetn           (iResetn),
      .iStart            (iStart),
      .iReact            (iReact),
      .iCountComplete    (iCountComplete),
      .iUpCount          (iUpCount),
      .oStart_down_count (oStart_down_count),
      .oStart_up_count   (oStart_up_count),
      .oLoad_score       (oLoad_score),
      .oScreen           (oScreen),
      .oFalseStart       (oFalseStart),
      .oTimeout          (oTimeout),
      .oState            (oState)
   );

   // Per-cycle activity counts and state/output legality, sampled before each edge updates
   always @(posedge clk) begin
      if (oStart_down_count) n_down++;
      if (oStart_up_count)   n_up++;
      if (oScreen)           n_screen++;
      if (oLoad_score)       n_load++;
      if (oScreen && !(oState == 3'd3 || oState == 3'd4)) n_bad++;
      if (oStart_down_count && oState != 3'd1) n_bad++;
      if (oStart_up_count && oState != 3'd3)   n_bad++;
      if (oLoad_score && oState != 3'd5)       n_bad++;
   end

   function automatic int out_vec();
      return int'({oState, oStart_down_count, oStart_up_count, oLoad_score,
                   oScreen, oFalseStart, oTimeout});
   endfunction

   task automatic chk(input string tag, input int obs, input int exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_state(input int target, input int budget, input string tag, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (int'(oState) != target && n < budget);
      chk(tag, int'(oState), target);
   endtask

   task automatic press_start();
      iStart = 1'b1;
      repeat (2) @(negedge clk);
      iStart = 1'b0;
   endtask

   task automatic press_react();
      iReact = 1'b1;
      repeat (2) @(negedge clk);
      iReact = 1'b0;
   endtask

   // One full attempt; outcome predicted from mode, the GO/REACT cycle j of the press and the 3-cycle edge latency
   task automatic attempt(input int mode, input int wait_k, input int j, input int upc);
      int n;
      int b_down, b_up, b_screen, b_load;
      int e_state, e_fs, e_to, e_load, e_screen, e_up;
      case (mode)
         M_NORMAL:  begin e_state = 6; e_fs = 0; e_to = 0; e_load = 1; e_screen = HOLD + j + 3; e_up = HOLD; end
         M_INGO:    begin e_state = 6; e_fs = 0; e_to = 0; e_load = 1; e_screen = HOLD + 1;     e_up = HOLD; end
         M_TIMEOUT: begin e_state = 7; e_fs = 0; e_to = 1; e_load = 0; e_screen = HOLD + j;     e_up = HOLD; end
         default:   begin e_state = 7; e_fs = 1; e_to = 0; e_load = 0; e_screen = 0;            e_up = 0;    end
      endcase
      b_down = n_down; b_up = n_up; b_screen = n_screen; b_load = n_load;

      press_start();
      wait_state(1, 10, "arm_entry", n);
      chk("start_latency", n, 2);
      chk("arm_flags", int'({oFalseStart, oTimeout}), 0);
      wait_state(2, HOLD + 4, "wait_entry", n);
      chk("arm_length", n_down - b_down, HOLD);
      repeat (wait_k) @(negedge clk);

      case (mode)
         M_FALSE: begin
            press_react();
            wait_state(7, 8, "false_abort", n);
         end
         M_SIMUL: begin
            press_react();
            @(negedge clk);
            iCountComplete = 1'b1;
            @(negedge clk);
            iCountComplete = 1'b0;
            chk("simul_state", int'(oState), 7);
         end
         default: begin
            iCountComplete = 1'b1;
            @(negedge clk);
            iCountComplete = 1'b0;
            chk("go_entry", int'(oState), 3);
            if (mode == M_INGO) begin
               repeat (j - 1) @(negedge clk);
               press_react();
               wait_state(6, HOLD + 10, "ingo_result", n);
            end else begin
               wait_state(4, HOLD + 2, "react_entry", n);
               repeat (j - 1) @(negedge clk);
               if (mode == M_NORMAL) begin
                  iUpCount = 12'(upc);
                  press_react();
                  wait_state(6, 10, "normal_result", n);
               end else begin
                  iUpCount = 12'd4095;
                  @(negedge clk);
                  chk("timeout_state", int'(oState), 7);
               end
            end
         end
      endcase

      @(negedge clk);
      iUpCount = 12'd0;
      chk("final_state", int'(oState), e_state);
      chk("false_start", int'(oFalseStart), e_fs);
      chk("timeout_flag", int'(oTimeout), e_to);
      chk("load_pulses", n_load - b_load, e_load);
      chk("screen_cycles", n_screen - b_screen, e_screen);
      chk("up_cycles", n_up - b_up, e_up);
   endtask

   initial begin
      int n;
      int mode;
      int jr;
      iResetn = 1'b0;
      iStart = 1'b0;
      iReact = 1'b0;
      iCountComplete = 1'b0;
      iUpCount = 12'd0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", out_vec(), 0);
      iResetn = 1'b1;
      repeat (5) @(negedge clk);
      chk("idle_after_reset", int'(oState), 0);

      attempt(M_NORMAL, 200, 10, 250);
      attempt(M_FALSE, 37, 1, 0);
      attempt(M_TIMEOUT, 15, 5, 0);
      attempt(M_SIMUL, 60, 1, 0);
      attempt(M_INGO, 20, HOLD - 2, 0);
      attempt(M_INGO, 5, 1, 0);
      attempt(M_NORMAL, 0, 1, 4094);

      for (int k = 0; k < 10; k++) begin
         mode = int'($urandom_range(0, 4));
         jr = (mode == M_INGO) ? int'($urandom_range(1, HOLD - 2)) : int'($urandom_range(1, 40));
         attempt(mode, int'($urandom_range(0, 300)), jr, int'($urandom_range(0, 4094)));
      end

      press_start();
      wait_state(2, HOLD + 10, "rst_wait", n);
      iCountComplete = 1'b1;
      @(negedge clk);
      iCountComplete = 1'b0;
      wait_state(4, HOLD + 4, "rst_react", n);
      repeat (3) @(negedge clk);
      #2;
      iResetn = 1'b0;
      iReact = 1'b1;
      iStart = 1'b1;
      #1;
      chk("async_reset_outputs", out_vec(), 0);
      @(negedge clk);
      iResetn = 1'b1;
      repeat (20) @(negedge clk);
      chk("held_buttons_idle", int'(oState), 0);
      chk("held_buttons_outputs", out_vec(), 0);
      iStart = 1'b0;
      iReact = 1'b0;
      repeat (4) @(negedge clk);
      attempt(M_FALSE, 3, 1, 0);

      chk("output_state_rules", n_bad, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
